// File: rtl/io_port_unit.sv
// -----------------------------------------------------------------------------
// io_port_unit
//
// Port I/O execution stage behind the control unit. A single I/O instruction
// (io_enable + io_dir + port_addr + wdata) either reads one of NPORTS input
// handshake ports into rdata or writes one of NPORTS output holding registers.
// When the addressed peripheral is not ready, io_wait is raised combinationally
// so the control unit holds the PC and the instruction. The block then waits
// in WAIT with its own latched copy of the request.
//
// Parameters
//   WIDTH    data width of every port
//   NPORTS   number of input ports and of output ports (power of two, >= 2)
//   TIMEOUT  WAIT-cycle bound, only used when IO_PORT_TIMEOUT_EN is defined
//
// Optional feature macro
//   IO_PORT_TIMEOUT_EN  bounds WAIT with a counter. When it expires, the read
//                       returns all ones, or the write is dropped, and the
//                       sticky io_err flag is set. Without the macro, WAIT is
//                       unbounded and io_err is tied low.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous active-low reset
//   io_enable  I/O instruction active this cycle
//   io_dir     0 = read (REG<-PORT), 1 = write (PORT<-REG/INM)
//   port_addr  target port
//   wdata      write data
//   rdata      registered read result
//   io_wait    combinational stall request to the control unit
//   io_err     sticky timeout flag
//   in_data    input port p at bits [p*WIDTH +: WIDTH]
//   in_valid   peripheral holds data on input port p
//   in_ack     one-cycle registered pulse, input port p consumed
//   out_data   output holding registers, port p at [p*WIDTH +: WIDTH]
//   out_valid  holding register p full
//   out_ready  peripheral takes out_data[p] this cycle
//   dbg_state  current FSM state (0 = IDLE, 1 = WAIT)
//
// Handshakes: an input port transfers on a rising edge where the port is
// addressed by a read that completes. A read completes when in_valid[p] is
// high and in_ack[p] is low. An output port drains on every rising edge
// where out_valid[q] and out_ready[q] are both high.
// -----------------------------------------------------------------------------
module io_port_unit #(
    parameter int WIDTH   = 8,
    parameter int NPORTS  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        io_enable,
    input  logic                        io_dir,
    input  logic [$clog2(NPORTS)-1:0]   port_addr,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata,
    output logic                        io_wait,
    output logic                        io_err,
    input  logic [NPORTS*WIDTH-1:0]     in_data,
    input  logic [NPORTS-1:0]           in_valid,
    output logic [NPORTS-1:0]           in_ack,
    output logic [NPORTS*WIDTH-1:0]     out_data,
    output logic [NPORTS-1:0]           out_valid,
    input  logic [NPORTS-1:0]           out_ready,
    output logic                        dbg_state
);

    localparam int AW = $clog2(NPORTS);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_nx;

    // Request copy that is captured on IDLE->WAIT
    logic             lat_dir;
    logic [AW-1:0]    lat_addr;
    logic [WIDTH-1:0] lat_wdata;

    // Effective request: the live inputs in IDLE and the latched copy in WAIT
    logic             req_dir;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;

    logic              busy;
    logic              complete;
    logic              abort;
    logic              do_xfer;
    logic              enter_wait;
    logic [WIDTH-1:0]  rd_word;
    logic [NPORTS-1:0] ack_nx;
    logic [NPORTS-1:0] wr_sel;

    assign dbg_state = (state == WAIT);

    // -------------------------------------------------------------------------
    // Request selection and completion
    // -------------------------------------------------------------------------
    always_comb begin
        req_dir   = io_dir;
        req_addr  = port_addr;
        req_wdata = wdata;
        if (state == WAIT) begin
            req_dir   = lat_dir;
            req_addr  = lat_addr;
            req_wdata = lat_wdata;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (req_addr == AW'(p)) begin
                rd_word = in_data[p*WIDTH +: WIDTH];
            end
        end
    end

    // A port that is acking this cycle is treated as not valid. The
    // peripheral has not yet seen the ack, so its data is stale. This
    // blocks a double read.
    always_comb begin
        busy = ((state == IDLE) && io_enable) || (state == WAIT);
        if (req_dir) begin
            complete = !out_valid[req_addr] || out_ready[req_addr];
        end else begin
            complete = in_valid[req_addr] && !in_ack[req_addr];
        end
        do_xfer    = busy && complete;
        enter_wait = (state == IDLE) && busy && !complete;
    end

`ifdef IO_PORT_TIMEOUT_EN
    // Counter width: at least 8 bits, wider if TIMEOUT needs it
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] tmo_cnt;
    logic          err_q;

    // The counter is 0 in the first WAIT cycle. With the request cycle,
    // this gives TIMEOUT cycles of io_wait before the abort cycle.
    always_comb begin
        abort = (state == WAIT) && !complete && (tmo_cnt == TMO_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign io_err = err_q;
`else
    logic unused_timeout;

    always_comb begin
        abort = 1'b0;
    end

    assign io_err         = 1'b0;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    assign io_wait = busy && !complete && !abort;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        if (do_xfer || abort) begin
            state_nx = IDLE;
        end else if (busy) begin
            state_nx = WAIT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_dir   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (enter_wait) begin
            lat_dir   <= io_dir;
            lat_addr  <= port_addr;
            lat_wdata <= wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Read path
    // -------------------------------------------------------------------------
    always_comb begin
        ack_nx = '0;
        if (do_xfer && !req_dir) begin
            ack_nx[req_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata  <= '0;
            in_ack <= '0;
        end else begin
            in_ack <= ack_nx;
            if (do_xfer && !req_dir) begin
                rdata <= rd_word;
            end else if (abort && !req_dir) begin
                rdata <= '1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Write path: holding registers with a drain on out_ready
    // -------------------------------------------------------------------------
    always_comb begin
        wr_sel = '0;
        if (do_xfer && req_dir) begin
            wr_sel[req_addr] = 1'b1;
        end
    end

    // A write on the same edge as a drain wins. The register stays full
    // and holds the new data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (wr_sel[p]) begin
                    out_data[p*WIDTH +: WIDTH] <= req_wdata;
                    out_valid[p]               <= 1'b1;
                end else if (out_valid[p] && out_ready[p]) begin
                    out_valid[p] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_io_port_unit.sv
// -----------------------------------------------------------------------------
// tb_io_port_unit
//
// Self-checking bench for io_port_unit (WIDTH=8, NPORTS=4). A behavioural
// model tracks the pending instruction, the holding registers and the acks
// with plain arrays. One compare process checks every DUT output against the
// model at each falling edge. The directed scenarios add hand-computed literal
// expectations. The bench then runs a randomized phase that includes random
// reset pulses. When the bench is compiled with IO_PORT_TIMEOUT_EN, the DUT
// is built with TIMEOUT=4.
// -----------------------------------------------------------------------------
module tb_io_port_unit;

`ifdef IO_PORT_TIMEOUT_EN
    localparam int TO    = 4;
    localparam int STALL = 3;
`else
    localparam int TO    = 255;
    localparam int STALL = 5;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        io_enable = 1'b0;
    logic        io_dir = 1'b0;
    logic [1:0]  port_addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        io_wait;
    logic        io_err;
    logic [31:0] in_data = '0;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ack;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic        dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    io_port_unit #(.WIDTH(8), .NPORTS(4), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .io_enable(io_enable), .io_dir(io_dir),
        .port_addr(port_addr), .wdata(wdata), .rdata(rdata), .io_wait(io_wait),
        .io_err(io_err), .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_od [4];
    bit         m_ov [4];
    bit         m_ack[4];
    logic [7:0] m_rdata;
    bit         m_err;
    bit         p_act;
    bit         p_dir;
    int         p_addr;
    logic [7:0] p_data;
    int         p_cnt;

    task automatic model_reset();
        for (int q = 0; q < 4; q++) begin
            m_od[q] = 8'h00; m_ov[q] = 0; m_ack[q] = 0;
        end
        m_rdata = 8'h00; m_err = 0; p_act = 0; p_dir = 0; p_addr = 0;
        p_data = 8'h00; p_cnt = 0;
    endtask

    // Compare process: outputs are stable at the falling edge and inputs
    // were driven shortly after the preceding rising edge.
    always @(negedge clk) begin
        bit          req, dir, cpl, abt;
        int          a;
        logic [7:0]  d;
        logic [31:0] e_od;
        logic [3:0]  e_ov, e_ack;

        if (!reset) model_reset();

        req = 0; dir = 0; a = 0; d = 8'h00; cpl = 0; abt = 0;
        if (p_act) begin
            req = 1; dir = p_dir; a = p_addr; d = p_data;
        end else if (io_enable) begin
            req = 1; dir = io_dir; a = int'(port_addr); d = wdata;
        end
        if (req) cpl = dir ? (!m_ov[a] || out_ready[a]) : (in_valid[a] && !m_ack[a]);
`ifdef IO_PORT_TIMEOUT_EN
        abt = p_act && !cpl && (p_cnt == TO - 1);
`endif

        for (int q = 0; q < 4; q++) begin
            e_od[q*8 +: 8] = m_od[q];
            e_ov[q]        = m_ov[q];
            e_ack[q]       = m_ack[q];
        end
        check("io_wait",   {31'd0, io_wait},   {31'd0, req && !cpl && !abt});
        check("rdata",     {24'd0, rdata},     {24'd0, m_rdata});
        check("out_data",  out_data,           e_od);
        check("out_valid", {28'd0, out_valid}, {28'd0, e_ov});
        check("in_ack",    {28'd0, in_ack},    {28'd0, e_ack});
        check("io_err",    {31'd0, io_err},    {31'd0, m_err});
        check("dbg_state", {31'd0, dbg_state}, {31'd0, p_act});

        if (reset) begin
            for (int q = 0; q < 4; q++) begin
                m_ack[q] = 0;
                if (m_ov[q] && out_ready[q]) m_ov[q] = 0;
            end
            if (req && cpl) begin
                if (dir) begin
                    m_od[a] = d; m_ov[a] = 1;
                end else begin
                    m_rdata = in_data[a*8 +: 8]; m_ack[a] = 1;
                end
                p_act = 0;
            end else if (abt) begin
                if (!dir) m_rdata = 8'hFF;
                m_err = 1; p_act = 0;
            end else if (req) begin
                if (!p_act) begin
                    p_act = 1; p_dir = dir; p_addr = a; p_data = d; p_cnt = 0;
                end else begin
                    p_cnt++;
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  n;
        bit  w;

        model_reset();
        tick(); tick(); tick();
        sample();
        check("rst_rdata",     {24'd0, rdata},     32'h0);
        check("rst_out_valid", {28'd0, out_valid}, 32'h0);
        check("rst_out_data",  out_data,           32'h0);
        check("rst_in_ack",    {28'd0, in_ack},    32'h0);
        check("rst_io_err",    {31'd0, io_err},    32'h0);
        tick();
        reset = 1'b1;

        // T1: zero-stall read of port 2
        io_enable = 1; io_dir = 0; port_addr = 2;
        in_valid = 4'b0100; in_data = 32'h00A5_0000;
        sample(); check("t1_wait", {31'd0, io_wait}, 32'h0);
        tick(); io_enable = 0;
        sample();
        check("t1_rdata", {24'd0, rdata}, 32'hA5);
        check("t1_ack",   {28'd0, in_ack}, 32'h4);
        tick(); in_valid = 4'b0000;
        sample(); check("t1_ack_off", {28'd0, in_ack}, 32'h0);

        // T2: write to empty port 1, then a blocked write
        tick(); io_enable = 1; io_dir = 1; port_addr = 1; wdata = 8'h3C; out_ready = 4'b0000;
        sample(); check("t2_w1_wait", {31'd0, io_wait}, 32'h0);
        tick(); io_enable = 0;
        sample();
        check("t2_w1_data",  {24'd0, out_data[15:8]}, 32'h3C);
        check("t2_w1_valid", {31'd0, out_valid[1]},   32'h1);
        tick(); io_enable = 1; io_dir = 1; port_addr = 1; wdata = 8'h55;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            sample(); if (io_wait) n++;
            tick();
        end
        out_ready = 4'b0010;
        sample();
        check("t2_w2_release", {31'd0, io_wait}, 32'h0);
        check("t2_w2_stall",   n, 3);
        tick(); io_enable = 0; out_ready = 4'b0000;
        sample();
        check("t2_w2_data",  {24'd0, out_data[15:8]}, 32'h55);
        check("t2_w2_valid", {31'd0, out_valid[1]},   32'h1);

        // T3: read of port 0 that stalls until data arrives
        tick(); io_enable = 1; io_dir = 0; port_addr = 0; in_valid = 4'b0000;
        n = 0;
        for (int c = 0; c < STALL; c++) begin
            sample(); if (io_wait) n++;
            tick();
        end
        in_valid = 4'b0001; in_data = 32'h0000_0011;
        sample(); check("t3_release", {31'd0, io_wait}, 32'h0);
        tick(); io_enable = 0;
        sample();
        check("t3_rdata", {24'd0, rdata},  32'h11);
        check("t3_ack",   {28'd0, in_ack}, 32'h1);
        check("t3_stall", n, STALL);
        tick(); in_valid = 4'b0000;
        sample(); check("t3_ack_once", {28'd0, in_ack}, 32'h0);

        // T4: back-to-back reads of port 3 with in_valid held
        tick(); io_enable = 1; io_dir = 0; port_addr = 3;
        in_valid = 4'b1000; in_data = 32'h7700_0000;
        sample(); check("t4_r1_wait", {31'd0, io_wait}, 32'h0);
        tick(); in_data = 32'h8800_0000;
        sample();
        check("t4_r1_rdata", {24'd0, rdata},   32'h77);
        check("t4_r1_ack",   {28'd0, in_ack},  32'h8);
        check("t4_r2_block", {31'd0, io_wait}, 32'h1);
        tick();
        sample();
        check("t4_gap_ack",  {28'd0, in_ack},  32'h0);
        check("t4_r2_wait",  {31'd0, io_wait}, 32'h0);
        tick(); io_enable = 0;
        sample();
        check("t4_r2_rdata", {24'd0, rdata},  32'h88);
        check("t4_r2_ack",   {28'd0, in_ack}, 32'h8);
        tick(); in_valid = 4'b0000;

        // T5: reset during a blocked write
        io_enable = 1; io_dir = 1; port_addr = 0; wdata = 8'hAA; out_ready = 4'b0000;
        sample(); check("t5_w1_wait", {31'd0, io_wait}, 32'h0);
        tick(); wdata = 8'hBB;
        sample(); check("t5_w2_wait", {31'd0, io_wait}, 32'h1);
        tick();
        sample(); check("t5_w2_hold", {31'd0, io_wait}, 32'h1);
        tick(); reset = 1'b0; io_enable = 0;
        sample();
        check("t5_valid", {28'd0, out_valid}, 32'h0);
        check("t5_wait",  {31'd0, io_wait},   32'h0);
        check("t5_data",  out_data,           32'h0);
        check("t5_state", {31'd0, dbg_state}, 32'h0);
        tick(); reset = 1'b1;

`ifdef IO_PORT_TIMEOUT_EN
        // T6: read of an idle port that times out
        io_enable = 1; io_dir = 0; port_addr = 1; in_valid = 4'b0000;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            sample(); if (io_wait) n++;
            tick();
        end
        sample(); check("t6_abort_wait", {31'd0, io_wait}, 32'h0);
        tick(); io_enable = 0;
        sample();
        check("t6_rdata", {24'd0, rdata},  32'hFF);
        check("t6_err",   {31'd0, io_err}, 32'h1);
        check("t6_noack", {28'd0, in_ack}, 32'h0);
        check("t6_stall", n, 4);
        tick(); tick(); tick();
        sample(); check("t6_err_sticky", {31'd0, io_err}, 32'h1);
`endif

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            sample(); w = io_wait;
            tick();
            reset     = ($urandom_range(0, 299) != 0);
            in_data   = $urandom;
            in_valid  = {($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
                         ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4)};
            out_ready = 4'($urandom);
            if (!reset) begin
                io_enable = 0;
            end else if (!w) begin
                io_enable = ($urandom_range(0, 2) != 0);
                io_dir    = 1'($urandom);
                port_addr = 2'($urandom);
                wdata     = 8'($urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                // Fields seen during WAIT must be ignored
                io_enable = 1'($urandom);
                io_dir    = 1'($urandom);
                port_addr = 2'($urandom);
                wdata     = 8'($urandom);
            end
        end
        sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
